sum_game_ctrl_param: RTL
========================

// Module: sum_game_ctrl_param
// PURPOSE
//  Parametrised game core for the scrambled-number sum game.
//  - Fetches NUM_OPS scrambled operands from an internal ROM, one per button press, addressed by toggle_switch.
//  - Checks the player's guessed sum against the true sum.
//  - Drives green/red result LEDs, a retry limit and a saturating score.
//  - Sits between the debounced button/switch inputs and the seven-segment decoders.
// PARAMETERS
//  DATA_W      4  operand width, bits
//  NUM_OPS     2  operands per round (legal 2..4)
//  ADDR_W      4  ROM address width (depth = 2**ADDR_W)
//  SEED        3  scramble offset
//  MAX_TRIES   3  wrong guesses allowed per round (>=1)
//  RESULT_HOLD 8  cycles an LED is held after a check (>=1)
//  SCORE_W     8  score width
//  Derived: SUM_W = DATA_W + $clog2(NUM_OPS); CNT_W = $clog2(NUM_OPS+1)
// PORTS
//  clk           in   1               system clock, rising edge
//  rst           in   1               reset, synchronous, active-high
//  button_pulse  in   1               single-cycle strobe: load operand / submit guess
//  toggle_switch in   ADDR_W          ROM address for the next operand
//  guess_sw      in   SUM_W           player's guessed sum
//  operands      out  NUM_OPS*DATA_W  loaded operands; op k at [k*DATA_W +: DATA_W]
//  op_count      out  CNT_W           operands loaded this round
//  sum_out       out  SUM_W           true sum; valid only in WIN/LOSE, else 0
//  tries_left    out  2..$clog2(MAX_TRIES+1) bits  remaining guesses
//  score         out  SCORE_W         rounds won, saturating
//  green_led     out  1               high during WIN hold
//  red_led       out  1               high during WRONG/LOSE hold
// BEHAVIOUR
//  - ROM: rom[a] = (a*7 + SEED) mod 2**DATA_W. Registered read, 1-cycle latency.
//  - Reset (sync, rst=1 at posedge):
//    - state=LOAD; operands, op_count, sum_out, score and both LEDs cleared to 0.
//    - tries_left=MAX_TRIES; hold counter=0.
//    - Reset mid-round aborts the round with no score change.
//  - States:
//    - LOAD:  button_pulse latches toggle_switch, issues the ROM read, -> FETCH.
//    - FETCH: ROM data stored at slot op_count; op_count+1.
//             -> GUESS if op_count becomes NUM_OPS, else -> LOAD.
//             Press-to-operand-visible latency = 2 cycles.
//    - GUESS: button_pulse compares guess_sw to the SUM_W-wide sum of the operands.
//             - equal -> WIN; score+1, saturating at 2**SCORE_W-1.
//             - unequal and tries_left>1 -> WRONG; tries_left-1.
//             - unequal and tries_left==1 -> LOSE; tries_left=0.
//    - WIN/WRONG/LOSE: LED asserted RESULT_HOLD cycles, starting the cycle after the check.
//             - WRONG exit -> GUESS.
//             - WIN/LOSE exit -> LOAD; operands, op_count, sum_out cleared; tries_left=MAX_TRIES.
//  - button_pulse is ignored in FETCH, WIN, WRONG and LOSE; it is not queued.
//  - Sum is computed at full SUM_W width, so there is no wrap.
//  - guess_sw is compared over all SUM_W bits.
//  - Never both LEDs high. Outputs are registered only.
// TESTING (defaults)
//  1 load addr 1, addr 2 -> operands 10,1, op_count 2 two cycles after 2nd press;
//    guess 11 -> green 8 cycles, score 1, sum_out 11, then LOAD.
//  2 same operands, guess 12 -> red 8 cycles, tries_left 2, state GUESS, score unchanged.
//  3 three wrong guesses (12,13,0) -> third gives LOSE, red 8 cycles, sum_out 11;
//    then tries_left 3, op_count 0.
//  4 load addr 4 twice -> operands 15,15; guess 30 -> WIN; next round guess 14 -> WRONG (no wrap).
//  5 press button during FETCH and during WIN hold -> no extra operand, no score change.
//  6 assert rst in FETCH after one press -> next edge all outputs at reset values.
//    Force score 255 then win -> score stays 255.

Source files
------------

// File: rtl/sum_game_ctrl_param.sv
// Game core for the scrambled-number sum game: loads NUM_OPS operands from a scramble ROM,
// checks the player's guessed sum, and drives result LEDs, retry limit and saturating score.
module sum_game_ctrl_param #(
  parameter int DATA_W      = 4,
  parameter int NUM_OPS     = 2,
  parameter int ADDR_W      = 4,
  parameter int SEED        = 3,
  parameter int MAX_TRIES   = 3,
  parameter int RESULT_HOLD = 8,
  parameter int SCORE_W     = 8,
  localparam int SUM_W      = DATA_W + $clog2(NUM_OPS),
  localparam int CNT_W      = $clog2(NUM_OPS + 1),
  localparam int TRY_W      = ($clog2(MAX_TRIES + 1) < 2) ? 2 : $clog2(MAX_TRIES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button_pulse,
  input  logic [ADDR_W-1:0]         toggle_switch,
  input  logic [SUM_W-1:0]          guess_sw,
  output logic [NUM_OPS*DATA_W-1:0] operands,
  output logic [CNT_W-1:0]          op_count,
  output logic [SUM_W-1:0]          sum_out,
  output logic [TRY_W-1:0]          tries_left,
  output logic [SCORE_W-1:0]        score,
  output logic                      green_led,
  output logic                      red_led
);

  localparam int HOLD_W = $clog2(RESULT_HOLD + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_GUESS,
    S_WIN,
    S_WRONG,
    S_LOSE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   rom_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [SUM_W-1:0]    sum_c;

  // Scramble table; truncation to DATA_W bits is the modulo.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    int unsigned v;
    v = 32'(a) * 32'd7 + 32'(SEED);
    return DATA_W'(v);
  endfunction

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      sum_c = sum_c + SUM_W'(operands[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      rom_q      <= '0;
      operands   <= '0;
      op_count   <= '0;
      sum_out    <= '0;
      score      <= '0;
      green_led  <= 1'b0;
      red_led    <= 1'b0;
      tries_left <= TRY_W'(MAX_TRIES);
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (button_pulse) begin
            rom_q <= rom_fn(toggle_switch);
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          operands[op_count*DATA_W +: DATA_W] <= rom_q;
          op_count <= op_count + CNT_W'(1);
          state    <= (op_count == CNT_W'(NUM_OPS - 1)) ? S_GUESS : S_LOAD;
        end

        S_GUESS: begin
          if (button_pulse) begin
            hold_cnt <= HOLD_W'(RESULT_HOLD);
            if (guess_sw == sum_c) begin
              state     <= S_WIN;
              green_led <= 1'b1;
              sum_out   <= sum_c;
              if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
            end else if (tries_left > TRY_W'(1)) begin
              state      <= S_WRONG;
              red_led    <= 1'b1;
              tries_left <= tries_left - TRY_W'(1);
            end else begin
              state      <= S_LOSE;
              red_led    <= 1'b1;
              tries_left <= '0;
              sum_out    <= sum_c;
            end
          end
        end

        S_WRONG: begin
          if (hold_cnt == HOLD_W'(1)) begin
            hold_cnt <= '0;
            red_led  <= 1'b0;
            state    <= S_GUESS;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        // Round over either way: wipe the board for the next round.
        S_WIN, S_LOSE: begin
          if (hold_cnt == HOLD_W'(1)) begin
            hold_cnt   <= '0;
            green_led  <= 1'b0;
            red_led    <= 1'b0;
            operands   <= '0;
            op_count   <= '0;
            sum_out    <= '0;
            tries_left <= TRY_W'(MAX_TRIES);
            state      <= S_LOAD;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
